// File: rtl/sound_ctrl_pkg.sv
// rtl/sound_ctrl_pkg.sv - shared types and helpers for the clap command sequencer
//
// Purpose: FSM state encoding, command width and the count-to-LED thermometer
//          helper used by clap_command_sequencer.
// Ports:   none (package)
package sound_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EMIT    = 2'd2,
    LOCKOUT = 2'd3
  } clap_state_t;

  localparam int CMD_W = 2;

  function automatic logic [2:0] count_thermometer(input logic [CMD_W-1:0] count);
    logic [2:0] therm;
    case (count)
      2'd1:    therm = 3'b001;
      2'd2:    therm = 3'b011;
      2'd3:    therm = 3'b111;
      default: therm = 3'b000;
    endcase
    return therm;
  endfunction

endpackage

// File: rtl/sound_debouncer.sv
// rtl/sound_debouncer.sv - synchroniser, debouncer and rising-edge strobe for the mic input
//
// Purpose: brings the asynchronous mic output into the clk domain, only lets a
//          level change through after DEBOUNCE_CYCLES+1 consecutive cycles of
//          disagreement, and pulses rise_strobe for one cycle on each clean 0->1.
// Ports:
//   clk           in   system clock
//   reset_n       in   synchronous, active-low reset
//   sound_signal  in   asynchronous mic output, high = sound
//   clean_level   out  debounced level (registered)
//   rise_strobe   out  one-cycle pulse on clean_level 0->1 (from registers only)
module sound_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sound_signal,
  output logic clean_level,
  output logic rise_strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   clean_prev_q;
  logic                   sync_level;

  assign sync_level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sound_signal};
    cnt_d   = '0;
    clean_d = clean_q;
    // Counter only runs while the synchronised level disagrees; a single
    // agreeing cycle restarts the wait. On reaching the limit the level is
    // accepted and the counter drops back to 0 instead of wrapping.
    if (sync_level != clean_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        clean_d = sync_level;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
    end
  end

  assign clean_level = clean_q;
  assign rise_strobe = clean_q & ~clean_prev_q;

endmodule

// File: rtl/clap_command_sequencer.sv
// rtl/clap_command_sequencer.sv - turns mic claps into 1..MAX_CLAPS game commands
//
// Purpose: counts debounced claps into a burst closed by a gap timeout or by
//          reaching MAX_CLAPS, offers the count on a valid/ready handshake,
//          then ignores the mic for LOCKOUT_CYCLES.
// Ports:
//   clk, reset_n  in   system clock, synchronous active-low reset
//   enable        in   1 = listen for claps, 0 = abort/idle (ignored in EMIT)
//   sound_signal  in   asynchronous mic output
//   cmd_valid     out  command offered
//   cmd_ready     in   consumer accepts on cmd_valid & cmd_ready
//   cmd_count     out  clap count, zero when cmd_valid is low
//   busy          out  state != IDLE
//   drop_count    out  claps seen in EMIT/LOCKOUT, saturating at 255
//   LEDR          out  [9] clean level, [8] cmd_valid, [7] lockout, [2:0] count thermometer
// GAP_CYCLES must be >= 2.
module clap_command_sequencer
  import sound_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int GAP_CYCLES      = 25_000_000,
  parameter int LOCKOUT_CYCLES  = 50_000_000,
  parameter int MAX_CLAPS       = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sound_signal,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [CMD_W-1:0] cmd_count,
  output logic             busy,
  output logic [7:0]       drop_count,
  output logic [9:0]       LEDR
);

  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  logic clean_level, clap;

  sound_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk         (clk),
    .reset_n     (reset_n),
    .sound_signal(sound_signal),
    .clean_level (clean_level),
    .rise_strobe (clap)
  );

  clap_state_t       state_q, state_d;
  logic [CMD_W-1:0]  count_q, count_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [7:0]        drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gap_d   = gap_q;
    lock_d  = lock_q;
    drop_d  = drop_q;

    if ((state_q == EMIT || state_q == LOCKOUT) && clap && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end

    // The clap cycle itself is gap cycle 0, so the register is loaded with 1
    // for the following cycle; the timeout then lands GAP_CYCLES after the clap.
    case (state_q)
      IDLE: begin
        if (clap && enable) begin
          count_d = CMD_W'(1);
          gap_d   = GAP_W'(1);
          state_d = (MAX_CLAPS == 1) ? EMIT : COUNT;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
          gap_d   = '0;
        end else if (clap) begin
          count_d = count_q + CMD_W'(1);
          gap_d   = GAP_W'(1);
          if (count_q + CMD_W'(1) == CMD_W'(MAX_CLAPS)) state_d = EMIT;
        end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = EMIT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      EMIT: begin
        if (cmd_ready) begin
          state_d = LOCKOUT;
          lock_d  = '0;
        end
      end
      LOCKOUT: begin
        if (lock_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      gap_q   <= '0;
      lock_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      lock_q  <= lock_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd_valid  = (state_q == EMIT);
  assign cmd_count  = cmd_valid ? count_q : '0;
  assign busy       = (state_q != IDLE);
  assign drop_count = drop_q;
  assign LEDR       = {clean_level, cmd_valid, state_q == LOCKOUT, 4'b0000,
                       count_thermometer(count_q)};

endmodule

// File: tb/tb_clap_command_sequencer.sv
// tb/tb_clap_command_sequencer.sv - randomized self-checking bench for clap_command_sequencer
module tb_clap_command_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int GAP  = 20;
  localparam int LOCK = 10;
  localparam int MAXC = 3;
  localparam int LAT  = SYNC + DEB + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       sound_signal = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_count;
  logic       busy;
  logic [7:0] drop_count;
  logic [9:0] LEDR;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clap_command_sequencer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP),
    .LOCKOUT_CYCLES (LOCK),
    .MAX_CLAPS      (MAXC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sound_signal(sound_signal),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_count   (cmd_count),
    .busy        (busy),
    .drop_count  (drop_count),
    .LEDR        (LEDR)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: from the strobe times of a burst and the ready delay,
  // work out when the command appears, its count, when it is taken, when the
  // block is idle again and how many claps are dropped.
  function automatic bit plan(input int strobes[$], input int rdelay,
                              output int emit_at, output int ncount,
                              output int acc_at, output int idle_at,
                              output int drops);
    int deadline;
    ncount   = 1;
    deadline = strobes[0] + GAP;
    emit_at  = -1;
    drops    = 0;
    for (int i = 1; i < strobes.size(); i++) begin
      if (emit_at < 0) begin
        if (strobes[i] < deadline) begin
          ncount++;
          deadline = strobes[i] + GAP;
          if (ncount == MAXC) emit_at = strobes[i] + 1;
        end else begin
          emit_at = deadline;
        end
      end
    end
    if (emit_at < 0) emit_at = deadline;
    acc_at  = emit_at + rdelay;
    idle_at = acc_at + LOCK + 1;
    for (int i = 0; i < strobes.size(); i++) begin
      if (strobes[i] >= idle_at) return 1'b0;
      if (strobes[i] >= emit_at) drops++;
    end
    return 1'b1;
  endfunction

  task automatic run_burst(input int nclaps);
    int starts[$];
    int highs[$];
    int strobes[$];
    int emit_at, ncount, acc_at, idle_at, drops, rdelay;
    int base, t, h, stop, drop0;
    int v_rise, v_fall, b_fall, cnt_seen, led_seen, cnt_changes;
    bit prev_v, prev_b, ok;
    ok = 1'b0;
    emit_at = 0; ncount = 0; acc_at = 0; idle_at = 0; drops = 0; rdelay = 0;
    base = cyc + 3;
    for (int tries = 0; tries < 100 && !ok; tries++) begin
      starts.delete(); highs.delete(); strobes.delete();
      t = base;
      for (int i = 0; i < nclaps; i++) begin
        h = $urandom_range(6, 9);
        starts.push_back(t);
        highs.push_back(h);
        strobes.push_back(t + LAT);
        t += $urandom_range(h + 6, GAP);
      end
      rdelay = $urandom_range(0, 10);
      ok = plan(strobes, rdelay, emit_at, ncount, acc_at, idle_at, drops);
    end
    if (!ok) begin
      check_eq("burst_plan", 0, 1);
      return;
    end
    stop = idle_at;
    if (starts[nclaps-1] + highs[nclaps-1] + LAT + 2 > stop)
      stop = starts[nclaps-1] + highs[nclaps-1] + LAT + 2;
    stop += 3;
    v_rise = -1; v_fall = -1; b_fall = -1;
    cnt_seen = -1; led_seen = -1; cnt_changes = 0;
    prev_v = cmd_valid; prev_b = busy;
    drop0 = drop_count;
    while (cyc < stop) begin
      @(posedge clk); #1;
      sound_signal = 1'b0;
      for (int i = 0; i < nclaps; i++)
        if (cyc >= starts[i] && cyc < starts[i] + highs[i]) sound_signal = 1'b1;
      if (cyc >= acc_at)       cmd_ready = 1'b1;
      else if (cyc < emit_at)  cmd_ready = 1'($urandom_range(0, 1));
      else                     cmd_ready = 1'b0;
      @(negedge clk);
      if (cmd_valid && !prev_v) begin
        v_rise   = cyc;
        cnt_seen = cmd_count;
        led_seen = LEDR[2:0];
      end
      if (cmd_valid && prev_v && cmd_count != cnt_seen) cnt_changes++;
      if (!cmd_valid && prev_v) v_fall = cyc;
      if (!busy && prev_b) b_fall = cyc;
      prev_v = cmd_valid;
      prev_b = busy;
    end
    cmd_ready = 1'b0;
    check_eq("valid_rise_cycle", v_rise, emit_at);
    check_eq("cmd_count", cnt_seen, ncount);
    check_eq("count_leds", led_seen, (1 << ncount) - 1);
    check_eq("count_stable", cnt_changes, 0);
    check_eq("valid_fall_cycle", v_fall, acc_at + 1);
    check_eq("busy_fall_cycle", b_fall, idle_at);
    check_eq("drop_count", drop_count, drop0 + drops);
  endtask

  task automatic pulse(input int high, input int low);
    for (int i = 0; i < high + low; i++) begin
      @(posedge clk); #1;
      sound_signal = (i < high);
    end
  endtask

  initial begin
    int bad, saw_busy, saw_clean, saw_valid, drop0, waited;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_count", cmd_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_ledr", LEDR, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (3) @(posedge clk);

    // short glitches never make it through the debouncer
    bad = 0;
    for (int g = 0; g < 50; g++) begin
      int hi, lo;
      hi = $urandom_range(1, DEB - 1);
      lo = $urandom_range(2, 5);
      for (int i = 0; i < hi + lo; i++) begin
        @(posedge clk); #1;
        sound_signal = (i < hi);
        @(negedge clk);
        if (LEDR != 10'd0 || busy) bad++;
      end
    end
    check_eq("glitch_quiet_cycles", bad, 0);

    // claps while disabled are ignored, not dropped
    enable = 1'b0;
    drop0 = drop_count; saw_busy = 0; saw_clean = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      sound_signal = (i < 8);
      @(negedge clk);
      if (busy) saw_busy++;
      if (LEDR[9]) saw_clean++;
    end
    check_eq("disabled_clean_seen", saw_clean > 0, 1);
    check_eq("disabled_busy", saw_busy, 0);
    check_eq("disabled_drop", drop_count, drop0);
    enable = 1'b1;

    // abort: enable drops 5 cycles after the first clap strobe
    saw_busy = 0; saw_valid = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      sound_signal = (i < 8);
      if (i == LAT + 5) enable = 1'b0;
      @(negedge clk);
      if (busy) saw_busy++;
      if (cmd_valid) saw_valid++;
    end
    check_eq("abort_was_busy", saw_busy > 0, 1);
    check_eq("abort_no_valid", saw_valid, 0);
    check_eq("abort_busy_end", busy, 0);
    check_eq("abort_count_leds", LEDR[2:0], 0);
    enable = 1'b1;

    // randomized bursts of 1..4 claps against the model
    for (int n = 0; n < 12; n++) run_burst((n % 4) + 1);

    // reset while a command is pending
    cmd_ready = 1'b0;
    waited = 0;
    fork
      pulse(8, 4);
    join
    while (!cmd_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("emit_reached", cmd_valid, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("emit_rst_valid", cmd_valid, 0);
    check_eq("emit_rst_count", cmd_count, 0);
    check_eq("emit_rst_busy", busy, 0);
    check_eq("emit_rst_drop", drop_count, 0);
    check_eq("emit_rst_ledr", LEDR, 0);
    run_burst(1);
    run_burst(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
